// File: rtl/token_encoder_pkg.sv
// Shared types and constants for the greedy longest-match token encoder.
package token_encoder_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK_END,
        S_FETCH,
        S_CMP,
        S_NEXT_ENT,
        S_CODE_RD,
        S_EMIT,
        S_DONE,
        S_ERR
    } token_enc_state_t;

    localparam int   TERMINATOR   = 0;
    localparam logic FALLBACK_MSB = 1'b1;

    // Width able to hold a match length of 0..max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/token_encoder_if.sv
// Memory read ports, control/status and output code stream of the token encoder.
interface token_encoder_if #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int CODE_WIDTH    = 9,
    parameter int VOCAB_ENTRIES = 8,
    parameter int MAX_TOKEN_LEN = 4
);
    localparam int VOC_AW = $clog2(VOCAB_ENTRIES * MAX_TOKEN_LEN);
    localparam int ENT_W  = $clog2(VOCAB_ENTRIES);

    logic                  cs;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic [VOC_AW-1:0]     voc_addr;
    logic [DATA_WIDTH-1:0] voc_data;
    logic [ENT_W-1:0]      code_addr;
    logic [CODE_WIDTH-1:0] code_data;
    logic [CODE_WIDTH-1:0] out_code;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  cs, in_data, voc_data, code_data, out_ready,
        output in_addr, voc_addr, code_addr, out_code, out_valid, busy, done, err
    );

    modport slave (
        output cs, in_data, voc_data, code_data, out_ready,
        input  in_addr, voc_addr, code_addr, out_code, out_valid, busy, done, err
    );

endinterface

// File: rtl/token_match_unit.sv
// Per-character compare decision: continue, finish an entry, and whether it beats the best match.
module token_match_unit
    import token_encoder_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_TOKEN_LEN = 4,
    parameter int LEN_W         = 3
) (
    input  logic [DATA_WIDTH-1:0] v,
    input  logic [DATA_WIDTH-1:0] c,
    input  logic                  oob,
    input  logic [LEN_W-1:0]      k,
    input  logic [LEN_W-1:0]      best_len,
    output logic                  cont,
    output logic                  update,
    output logic [LEN_W-1:0]      len
);
    logic [DATA_WIDTH-1:0] c_eff;
    logic [LEN_W-1:0]      k_inc;
    logic                  hit;

    always_comb begin
        // Positions past the end of the input read as terminator instead of wrapping.
        c_eff  = oob ? '0 : c;
        k_inc  = k + LEN_W'(1);
        cont   = 1'b0;
        hit    = 1'b0;
        len    = k;
        if (v == DATA_WIDTH'(TERMINATOR)) begin
            hit = (k != '0);
        end else if (v == c_eff) begin
            if (k_inc == LEN_W'(MAX_TOKEN_LEN)) begin
                hit = 1'b1;
                len = k_inc;
            end else begin
                cont = 1'b1;
            end
        end
        // Strict compare: on equal length the earlier entry wins.
        update = hit && (len > best_len);
    end

endmodule

// File: rtl/token_encoder.sv
// Greedy longest-match tokenizer over external input/vocab/code RAMs with a back-pressured code stream.
// Optional feature macro FALLBACK_BYTE_EN: unmatched characters are emitted as raw bytes instead of raising err.
module token_encoder
    import token_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int CODE_WIDTH    = 9,
    parameter int VOCAB_ENTRIES = 8,
    parameter int MAX_TOKEN_LEN = 4
) (
    input logic             clk,
    input logic             rst,
    token_encoder_if.master bus
);
    localparam int VOC_AW = $clog2(VOCAB_ENTRIES * MAX_TOKEN_LEN);
    localparam int ENT_W  = $clog2(VOCAB_ENTRIES);
    localparam int LEN_W  = len_width(MAX_TOKEN_LEN);
    localparam int POS_W  = ADDR_WIDTH + 1;

    token_enc_state_t      state;
    logic [ADDR_WIDTH-1:0] pos;
    logic [ENT_W-1:0]      entry;
    logic [LEN_W-1:0]      k;
    logic [LEN_W-1:0]      best_len;
    logic [ENT_W-1:0]      best_idx;
    logic                  rd_wait;

    logic [ADDR_WIDTH-1:0] in_addr_r;
    logic [VOC_AW-1:0]     voc_addr_r;
    logic [ENT_W-1:0]      code_addr_r;
    logic [CODE_WIDTH-1:0] out_code_r;
    logic                  out_valid_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;

    logic                  oob;
    logic [LEN_W-1:0]      k_inc;
    logic [POS_W-1:0]      pos_adv;
    logic [VOC_AW-1:0]     voc_base;
    logic [VOC_AW-1:0]     voc_base_next;
    logic                  mu_cont;
    logic                  mu_update;
    logic [LEN_W-1:0]      mu_len;

    assign oob           = (POS_W'(pos) + POS_W'(k)) >= POS_W'(2**ADDR_WIDTH);
    assign k_inc         = k + LEN_W'(1);
    assign pos_adv       = POS_W'(pos) + POS_W'(best_len);
    assign voc_base      = VOC_AW'(entry) * VOC_AW'(MAX_TOKEN_LEN);
    assign voc_base_next = (VOC_AW'(entry) + VOC_AW'(1)) * VOC_AW'(MAX_TOKEN_LEN);

    token_match_unit #(
        .DATA_WIDTH    (DATA_WIDTH),
        .MAX_TOKEN_LEN (MAX_TOKEN_LEN),
        .LEN_W         (LEN_W)
    ) u_match (
        .v        (bus.voc_data),
        .c        (bus.in_data),
        .oob      (oob),
        .k        (k),
        .best_len (best_len),
        .cont     (mu_cont),
        .update   (mu_update),
        .len      (mu_len)
    );

`ifdef FALLBACK_BYTE_EN
    logic [DATA_WIDTH-1:0] cur_char;
    logic [CODE_WIDTH-1:0] fb_code;

    always_comb begin
        fb_code                 = '0;
        fb_code[DATA_WIDTH-1:0] = cur_char;
        fb_code[CODE_WIDTH-1]   = FALLBACK_MSB;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pos         <= '0;
            entry       <= '0;
            k           <= '0;
            best_len    <= '0;
            best_idx    <= '0;
            rd_wait     <= 1'b0;
            in_addr_r   <= '0;
            voc_addr_r  <= '0;
            code_addr_r <= '0;
            out_code_r  <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.cs) begin
                        done_r    <= 1'b0;
                        err_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        pos       <= '0;
                        in_addr_r <= '0;
                        rd_wait   <= 1'b1;
                        state     <= S_CHK_END;
                    end
                end
                // First cycle lets the RAM return the character at pos.
                S_CHK_END: begin
                    if (rd_wait) begin
                        rd_wait <= 1'b0;
                    end else if (bus.in_data == DATA_WIDTH'(TERMINATOR)) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= S_DONE;
                    end else begin
`ifdef FALLBACK_BYTE_EN
                        cur_char <= bus.in_data;
`endif
                        entry      <= '0;
                        k          <= '0;
                        best_len   <= '0;
                        best_idx   <= '0;
                        in_addr_r  <= pos;
                        voc_addr_r <= '0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_CMP;
                S_CMP: begin
                    if (mu_cont) begin
                        k          <= k_inc;
                        in_addr_r  <= pos + ADDR_WIDTH'(k_inc);
                        voc_addr_r <= voc_base + VOC_AW'(k_inc);
                        state      <= S_FETCH;
                    end else begin
                        if (mu_update) begin
                            best_len <= mu_len;
                            best_idx <= entry;
                        end
                        state <= S_NEXT_ENT;
                    end
                end
                S_NEXT_ENT: begin
                    if (entry == ENT_W'(VOCAB_ENTRIES - 1)) begin
                        if (best_len != '0) begin
                            code_addr_r <= best_idx;
                            rd_wait     <= 1'b1;
                            state       <= S_CODE_RD;
                        end else begin
`ifdef FALLBACK_BYTE_EN
                            out_code_r  <= fb_code;
                            out_valid_r <= 1'b1;
                            best_len    <= LEN_W'(1);
                            state       <= S_EMIT;
`else
                            err_r  <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= S_ERR;
`endif
                        end
                    end else begin
                        entry      <= entry + ENT_W'(1);
                        k          <= '0;
                        in_addr_r  <= pos;
                        voc_addr_r <= voc_base_next;
                        state      <= S_FETCH;
                    end
                end
                S_CODE_RD: begin
                    if (rd_wait) begin
                        rd_wait <= 1'b0;
                    end else begin
                        out_code_r  <= bus.code_data;
                        out_valid_r <= 1'b1;
                        state       <= S_EMIT;
                    end
                end
                // Code is held until the sink takes it; stepping past the last address ends the string.
                S_EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (pos_adv[ADDR_WIDTH]) begin
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            pos       <= pos_adv[ADDR_WIDTH-1:0];
                            in_addr_r <= pos_adv[ADDR_WIDTH-1:0];
                            rd_wait   <= 1'b1;
                            state     <= S_CHK_END;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_addr   = in_addr_r;
    assign bus.voc_addr  = voc_addr_r;
    assign bus.code_addr = code_addr_r;
    assign bus.out_code  = out_code_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule
